fifo_axis_read_port: RTL and testbench

- Read side of the FIFO_AXI buffer; mirror of the write-side pointer counter.
- Compares its own read pointer against the write-side binary pointer and issues reads to the dual-port RAM, which has 1-cycle read latency.
- Presents words as an AXI4-Stream master through a 2-entry output stage (main + skid), so it sustains 1 word/cycle under continuous tready.
- Same clock domain as the writer; no CDC.

---
 rtl/fifo_axis_read_port.sv | 92 +++++++++
 tb/tb_fifo_axis_read_port.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_axis_read_port.sv
// Read side of the FIFO_AXI buffer: issues RAM reads against the writer's pointer
// and presents returned words on an AXI4-Stream master through a main+skid stage.
module fifo_axis_read_port #(
  parameter int unsigned p_addr_width = 4,
  parameter int unsigned p_data_width = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_sclr,
  input  logic [p_addr_width:0]   i_wr_ptr,
  output logic [p_addr_width:0]   o_rd_ptr,
  output logic                    o_rd_en,
  output logic [p_addr_width-1:0] o_rd_addr,
  input  logic [p_data_width-1:0] i_rd_data,
  output logic [p_data_width-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [p_addr_width:0]   o_fill_count,
  output logic                    o_empty
);

  localparam int unsigned PW = p_addr_width + 1;

  logic [PW-1:0]           rd_ptr;
  logic                    main_valid;
  logic [p_data_width-1:0] main_data;
  logic                    skid_valid;
  logic [p_data_width-1:0] skid_data;
  logic                    inflight;

  logic                    ptr_empty;
  logic                    pop;
  logic [1:0]              out_cnt;
  logic [2:0]              slots;
  logic                    rd_en;

  // Credit check: a read may issue only if its data is guaranteed a slot on return.
  always_comb begin
    ptr_empty = (i_wr_ptr == rd_ptr);
    pop       = main_valid & m_axis_tready;
    out_cnt   = 2'(main_valid) + 2'(skid_valid);
    slots     = 3'(out_cnt) + 3'(inflight);
    rd_en     = i_reset_n & !ptr_empty & !i_sclr & ((slots - 3'(pop)) < 3'd2);
  end

  // Pointer, in-flight tracking and the main/skid output stage.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr     <= '0;
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      inflight   <= 1'b0;
    end else if (i_sclr) begin
      rd_ptr     <= i_wr_ptr;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      inflight   <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      if (pop) begin
        if (skid_valid) begin
          main_data  <= skid_data;
          skid_valid <= inflight;
          if (inflight) skid_data <= i_rd_data;
        end else begin
          main_valid <= inflight;
          if (inflight) main_data <= i_rd_data;
        end
      end else if (inflight) begin
        if (!main_valid) begin
          main_valid <= 1'b1;
          main_data  <= i_rd_data;
        end else begin
          skid_valid <= 1'b1;
          skid_data  <= i_rd_data;
        end
      end
    end
  end

  assign o_rd_ptr      = rd_ptr;
  assign o_rd_en       = rd_en;
  assign o_rd_addr     = rd_ptr[p_addr_width-1:0];
  assign m_axis_tdata  = main_data;
  assign m_axis_tvalid = main_valid;
  assign o_fill_count  = i_wr_ptr - rd_ptr;
  assign o_empty       = ptr_empty & !inflight & !main_valid;

endmodule

// File: tb/tb_fifo_axis_read_port.sv
// Directed bench for fifo_axis_read_port with a 1-cycle-latency RAM model.
module tb_fifo_axis_read_port;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sclr;
  logic [4:0] wr_ptr;
  logic [4:0] rd_ptr;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic [4:0] fill;
  logic       empty;

  logic [7:0] mem [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  fifo_axis_read_port #(.p_addr_width(4), .p_data_width(8)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_sclr(sclr), .i_wr_ptr(wr_ptr),
    .o_rd_ptr(rd_ptr), .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .o_fill_count(fill), .o_empty(empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] wrap_addr [4];
    logic [7:0] wrap_data [4];
    wrap_addr = '{4'd14, 4'd15, 4'd0, 4'd1};
    wrap_data = '{8'hE0, 8'hE1, 8'hE2, 8'hE3};
    reset_n = 1'b0; sclr = 1'b0; wr_ptr = 5'd0; tready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_tdata", 32'(tdata), 0);
    chk("rst_rd_ptr", 32'(rd_ptr), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_empty", 32'(empty), 1);
    @(negedge clk); reset_n = 1'b1;

    // single word
    mem[0] = 8'hA5; tready = 1'b1;
    @(negedge clk); wr_ptr = 5'd1; #1;
    chk("sw_rd_en_N", 32'(rd_en), 1);
    chk("sw_addr_N", 32'(rd_addr), 0);
    chk("sw_fill_N", 32'(fill), 1);
    @(negedge clk); #1;
    chk("sw_tvalid_N1", 32'(tvalid), 0);
    chk("sw_rd_en_N1", 32'(rd_en), 0);
    chk("sw_empty_N1", 32'(empty), 0);
    chk("sw_rd_ptr_N1", 32'(rd_ptr), 1);
    @(negedge clk); #1;
    chk("sw_tvalid_N2", 32'(tvalid), 1);
    chk("sw_tdata_N2", 32'(tdata), 32'hA5);
    @(negedge clk); #1;
    chk("sw_tvalid_N3", 32'(tvalid), 0);
    chk("sw_empty_N3", 32'(empty), 1);

    // full throughput
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h30 + i);
    @(negedge clk); sclr = 1'b1; wr_ptr = 5'd0; #1;
    chk("ft_sclr_rd_en", 32'(rd_en), 0);
    @(negedge clk); sclr = 1'b0; wr_ptr = 5'd16; #1;
    chk("ft_rd_en_c0", 32'(rd_en), 1);
    chk("ft_fill_c0", 32'(fill), 16);
    @(negedge clk);
    for (int c = 2; c <= 17; c++) begin
      @(negedge clk); #1;
      chk("ft_tvalid", 32'(tvalid), 1);
      chk("ft_tdata", 32'(tdata), 32'(8'h30 + c - 2));
    end
    @(negedge clk); #1;
    chk("ft_tvalid_end", 32'(tvalid), 0);
    chk("ft_rd_ptr_end", 32'(rd_ptr), 16);
    chk("ft_empty_end", 32'(empty), 1);

    // backpressure
    tready = 1'b0;
    for (int i = 0; i < 5; i++) mem[i] = 8'(8'h50 + i);
    @(negedge clk); wr_ptr = 5'd21; #1;
    chk("bp_rd_en_c0", 32'(rd_en), 1);
    @(negedge clk); #1;
    chk("bp_rd_en_c1", 32'(rd_en), 1);
    @(negedge clk); #1;
    chk("bp_rd_en_c2", 32'(rd_en), 0);
    repeat (3) begin
      @(negedge clk); #1;
      chk("bp_hold_rd_en", 32'(rd_en), 0);
      chk("bp_hold_fill", 32'(fill), 3);
      chk("bp_hold_tvalid", 32'(tvalid), 1);
      chk("bp_hold_tdata", 32'(tdata), 32'h50);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); tready = 1'b1; #1;
      chk("bp_pop_tvalid", 32'(tvalid), 1);
      chk("bp_pop_tdata", 32'(tdata), 32'(8'h50 + i));
    end
    @(negedge clk); #1;
    chk("bp_tvalid_end", 32'(tvalid), 0);
    chk("bp_rd_ptr_end", 32'(rd_ptr), 21);
    chk("bp_empty_end", 32'(empty), 1);

    // pointer wrap
    mem[14] = 8'hE0; mem[15] = 8'hE1; mem[0] = 8'hE2; mem[1] = 8'hE3;
    @(negedge clk); sclr = 1'b1; wr_ptr = 5'd30;
    @(negedge clk); sclr = 1'b0; wr_ptr = 5'd2;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c < 4) begin
        chk("wr_rd_en", 32'(rd_en), 1);
        chk("wr_addr", 32'(rd_addr), 32'(wrap_addr[c]));
        chk("wr_fill", 32'(fill), 32'(4 - c));
      end
      if (c >= 2) begin
        chk("wr_tvalid", 32'(tvalid), 1);
        chk("wr_tdata", 32'(tdata), 32'(wrap_data[c-2]));
      end
    end
    @(negedge clk); #1;
    chk("wr_rd_ptr_end", 32'(rd_ptr), 2);
    chk("wr_fill_end", 32'(fill), 0);
    chk("wr_empty_end", 32'(empty), 1);

    // flush with a word held and a read in flight
    tready = 1'b0; mem[2] = 8'h72; mem[3] = 8'h73;
    @(negedge clk); wr_ptr = 5'd9; #1;
    chk("fl_rd_en_c0", 32'(rd_en), 1);
    chk("fl_addr_c0", 32'(rd_addr), 2);
    @(negedge clk); #1;
    chk("fl_rd_en_c1", 32'(rd_en), 1);
    @(negedge clk); sclr = 1'b1; tready = 1'b1; #1;
    chk("fl_sclr_rd_en", 32'(rd_en), 0);
    chk("fl_sclr_tvalid", 32'(tvalid), 1);
    chk("fl_sclr_tdata", 32'(tdata), 32'h72);
    @(negedge clk); sclr = 1'b0; tready = 1'b0; #1;
    chk("fl_tvalid", 32'(tvalid), 0);
    chk("fl_tdata_kept", 32'(tdata), 32'h72);
    chk("fl_rd_ptr", 32'(rd_ptr), 9);
    chk("fl_empty", 32'(empty), 1);
    chk("fl_fill", 32'(fill), 0);
    chk("fl_rd_en", 32'(rd_en), 0);
    repeat (2) begin
      @(negedge clk); #1;
      chk("fl_late_tvalid", 32'(tvalid), 0);
    end

    // asynchronous reset mid-stream
    mem[9] = 8'hAA; mem[10] = 8'hBB; mem[11] = 8'hCC;
    @(negedge clk); wr_ptr = 5'd12;
    repeat (2) @(negedge clk);
    #1;
    chk("mr_tvalid_pre", 32'(tvalid), 1);
    chk("mr_tdata_pre", 32'(tdata), 32'hAA);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_tvalid", 32'(tvalid), 0);
    chk("mr_rd_ptr", 32'(rd_ptr), 0);
    chk("mr_rd_en", 32'(rd_en), 0);
    chk("mr_tdata", 32'(tdata), 0);
    @(negedge clk); wr_ptr = 5'd0; reset_n = 1'b1; #1;
    chk("mr_empty_rel", 32'(empty), 1);
    @(negedge clk); #1;
    chk("mr_empty_after", 32'(empty), 1);
    chk("mr_tvalid_after", 32'(tvalid), 0);
    chk("mr_fill_after", 32'(fill), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
